debug_frame_sender: RTL and testbench

Downstream stage of the debugger top-level FSM. It snapshots the wide MIPS debug dump plus the 32-bit run clock count and serialises it byte-by-byte into the UART transmitter using a start/done handshake. It signals completion back to the run-control FSM, which waits on this done before stepping or finishing. Sits between the debugger FSM/pipeline dump bus and the UART tx.

---
 rtl/debug_frame_sender_pkg.sv | 40 ++++
 rtl/debug_frame_sender_if.sv | 34 +++
 rtl/debug_frame_sender_frame_shift_reg.sv | 62 ++++++
 rtl/debug_frame_sender.sv | 134 +++++++++++++
 tb/tb_debug_frame_sender.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_frame_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_sender_pkg
// Description : Shared constants and types for the debug frame sender and
//               the debugger top level: frame geometry, byte-index width,
//               sender state encoding and host command codes.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_frame_sender_pkg;

    // Frame geometry
    localparam int DATA_W       = 2560;                  // pipeline dump width, multiple of 8
    localparam int N_DATA_BYTES = DATA_W / 8;            // 320 dump bytes
    localparam int N_CNT_BYTES  = 4;                     // clock-count bytes
    localparam int N_BYTES      = N_CNT_BYTES + N_DATA_BYTES; // 324 bytes per frame
    localparam int IDX_W        = 9;                     // byte index width

    localparam logic [IDX_W-1:0] c_IDX_LAST       = IDX_W'(N_BYTES - 1);
    localparam logic [IDX_W-1:0] c_IDX_FIRST_DATA = IDX_W'(N_CNT_BYTES);

    // Sender state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_START   = 2'd1;
    localparam logic [1:0] c_ST_WAIT_TX = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_START   = c_ST_START,
        ST_WAIT_TX = c_ST_WAIT_TX,
        ST_DONE    = c_ST_DONE
    } state_t;

    // Host command codes understood by the debugger top level
    localparam logic [7:0] c_CMD_LOAD = 8'h01;
    localparam logic [7:0] c_CMD_FAST = 8'h02;
    localparam logic [7:0] c_CMD_STEP = 8'h03;

endpackage
`default_nettype wire

// File: rtl/debug_frame_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_sender_if
// Description : Bundle of the run-control side (start/busy/done, dump and
//               clock count) and the UART transmitter side (tx_data,
//               tx_start, tx_done) of the debug frame sender.
//               slave  : the frame sender itself
//               master : whoever drives the frame sender (FSM / UART model)
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_frame_sender_if;
    import debug_frame_sender_pkg::*;

    logic              i_start;      // frame request
    logic [DATA_W-1:0] i_data;       // pipeline dump
    logic [31:0]       i_clk_count;  // executed cycle count
    logic              i_tx_done;    // UART finished current byte
    logic [7:0]        o_tx_data;    // byte to transmit
    logic              o_tx_start;   // UART start pulse
    logic              o_busy;       // frame in progress
    logic              o_done;       // last byte acknowledged

    modport slave (
        input  i_start, i_data, i_clk_count, i_tx_done,
        output o_tx_data, o_tx_start, o_busy, o_done
    );

    modport master (
        output i_start, i_data, i_clk_count, i_tx_done,
        input  o_tx_data, o_tx_start, o_busy, o_done
    );

endinterface
`default_nettype wire

// File: rtl/debug_frame_sender_frame_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : frame_shift_reg
// Description : Shadow register for one debug frame. Parallel-loads the
//               32-bit clock count and the DATA_W dump, then advances one
//               byte per shift. The count field drains from its MSB end, the
//               dump field from its LSB end; i_sel_cnt picks which field the
//               current byte comes from.
//               o_next_byte is the byte that will be current after this
//               clock edge (after a load or a shift), so the owner can
//               register it in the same cycle as the load/shift.
// Ports       : clk, rst (sync, active-low)
//               i_load, i_load_cnt, i_load_data : snapshot request and value
//               i_shift                         : advance by one byte
//               i_sel_cnt                       : current byte is a count byte
//               i_next_sel_cnt                  : byte after shift is a count byte
//               o_next_byte                     : byte presented after this edge
// Revision    : 1.0 - initial release
// ============================================================================
module frame_shift_reg
    import debug_frame_sender_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [31:0]       i_load_cnt,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic              i_sel_cnt,
    input  logic              i_next_sel_cnt,
    output logic [7:0]        o_next_byte
);

    logic [31:0]       r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       w_cnt_sh;
    logic [DATA_W-1:0] w_data_sh;

    // Only the field the current byte came from is consumed.
    assign w_cnt_sh  = i_sel_cnt ? {r_cnt[23:0], 8'h00} : r_cnt;
    assign w_data_sh = i_sel_cnt ? r_data : {8'h00, r_data[DATA_W-1:8]};

    // A fresh frame always begins with the count MSB.
    assign o_next_byte = i_load         ? i_load_cnt[31:24] :
                         i_next_sel_cnt ? w_cnt_sh[31:24]   :
                                          w_data_sh[7:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_cnt  <= i_load_cnt;
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_cnt  <= w_cnt_sh;
            r_data <= w_data_sh;
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : debug_frame_sender
// Description : Snapshots the pipeline dump and clock count on request and
//               serialises them byte by byte into the UART transmitter with
//               a start/done handshake. Signals frame completion with a
//               one-cycle done pulse. Clock count goes first (MSB first),
//               then the dump bytes LSB first.
// Ports       : clk  - clock
//               rst  - synchronous, active-low reset
//               bus  - debug_frame_sender_if.slave
//                      i_start, i_data, i_clk_count, i_tx_done (in)
//                      o_tx_data, o_tx_start, o_busy, o_done   (out, registered)
// Revision    : 1.0 - initial release
// ============================================================================
module debug_frame_sender
    import debug_frame_sender_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    debug_frame_sender_if.slave  bus
);

    state_t           r_state,    w_state_nxt;
    logic [IDX_W-1:0] r_idx,      w_idx_nxt;
    logic [7:0]       r_tx_data,  w_tx_data_nxt;
    logic             r_tx_start, w_tx_start_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;

    logic             w_load;
    logic             w_shift;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_sel_cnt;
    logic             w_next_sel_cnt;
    logic [7:0]       w_next_byte;

    assign w_idx_inc      = r_idx + IDX_W'(1);
    assign w_sel_cnt      = (r_idx < c_IDX_FIRST_DATA);
    assign w_next_sel_cnt = (w_idx_inc < c_IDX_FIRST_DATA);

    frame_shift_reg u_frame_shift_reg (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_load),
        .i_load_cnt     (bus.i_clk_count),
        .i_load_data    (bus.i_data),
        .i_shift        (w_shift),
        .i_sel_cnt      (w_sel_cnt),
        .i_next_sel_cnt (w_next_sel_cnt),
        .o_next_byte    (w_next_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Output registers are loaded on the transition into a state, so
    // o_tx_start is high exactly while the FSM sits in START and o_done
    // exactly while it sits in DONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_load         = 1'b0;
        w_shift        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_load         = 1'b1;
                    w_idx_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_tx_start_nxt = 1'b1;
                    w_tx_data_nxt  = w_next_byte;
                    w_state_nxt    = ST_START;
                end
            end

            // i_tx_done coinciding with the start pulse belongs to no byte.
            ST_START: begin
                w_state_nxt = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_shift        = 1'b1;
                        w_idx_nxt      = w_idx_inc;
                        w_tx_start_nxt = 1'b1;
                        w_tx_data_nxt  = w_next_byte;
                        w_state_nxt    = ST_START;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_tx_start;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_debug_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_frame_sender
// Description : Directed self-checking bench for debug_frame_sender. A single
//               stimulus thread plays the run-control FSM and the UART
//               transmitter; a passive monitor counts start/done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_frame_sender;
    import debug_frame_sender_pkg::*;

    logic clk;
    logic rst;

    debug_frame_sender_if bus ();

    debug_frame_sender dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int n_start_seen = 0;
    int n_done_seen  = 0;

    logic [7:0] got [N_BYTES];
    int         got_n;

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) n_start_seen++;
        if (bus.o_done === 1'b1)     n_done_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual=hung, required=finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mk_data(input int mul, input int add);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < N_DATA_BYTES; k++) d[8*k +: 8] = 8'(k * mul + add);
        return d;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] cnt, input logic [DATA_W-1:0] data,
                                            input int k);
        if (k < N_CNT_BYTES) return cnt[8*(N_CNT_BYTES-1-k) +: 8];
        return data[8*(k-N_CNT_BYTES) +: 8];
    endfunction

    task automatic start_frame(input logic [31:0] cnt, input logic [DATA_W-1:0] data);
        bus.i_clk_count = cnt;
        bus.i_data      = data;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start     = 1'b0;
    endtask

    // Called right after the edge that sampled i_start. mode 0: done 5
    // cycles after each start; mode 1: random 1..40. stop_at: reset after
    // that byte starts. poke_at: change inputs and pulse i_start at that
    // byte. spurious: pulse i_tx_done in every START cycle.
    task automatic run_frame(input int mode, input int stop_at, input int poke_at,
                             input bit spurious, input logic [31:0] alt_cnt,
                             input logic [DATA_W-1:0] alt_data);
        int lat;
        int bad;
        bad   = 0;
        got_n = 0;
        for (int b = 0; b < N_BYTES; b++) begin
            if (bus.o_tx_start !== 1'b1) begin
                check($sformatf("tx_start_timing_b%0d", b), {31'd0, bus.o_tx_start}, 32'd1);
                return;
            end
            got[b] = bus.o_tx_data;
            got_n  = b + 1;
            if (b == stop_at) begin
                rst = 1'b0;
                tick();
                tick();
                rst = 1'b1;
                return;
            end
            if (b == poke_at) begin
                bus.i_clk_count = alt_cnt;
                bus.i_data      = alt_data;
                bus.i_start     = 1'b1;
            end
            bus.i_tx_done = spurious;
            tick();
            bus.i_tx_done = 1'b0;
            bus.i_start   = 1'b0;
            lat = (mode == 0) ? 5 : int'($urandom_range(1, 40));
            for (int c = 1; c < lat; c++) begin
                if (bus.o_tx_data !== got[b] || bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) bad++;
                tick();
            end
            if (bus.o_tx_data !== got[b] || bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) bad++;
            bus.i_tx_done = 1'b1;
            tick();
            bus.i_tx_done = 1'b0;
        end
        check("hold_violations", bad, 0);
        check("done_pulse", {31'd0, bus.o_done}, 32'd1);
        check("busy_in_done", {31'd0, bus.o_busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, bus.o_done}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] cnt,
                               input logic [DATA_W-1:0] data);
        check({tag, "_len"}, got_n, N_BYTES);
        for (int k = 0; k < got_n; k++)
            check($sformatf("%s_b%0d", tag, k), {24'd0, got[k]}, {24'd0, exp_byte(cnt, data, k)});
    endtask

    initial begin
        int s0;
        int d0;
        logic [DATA_W-1:0] da;
        logic [DATA_W-1:0] db;

        rst             = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_data      = '0;
        bus.i_clk_count = '0;
        bus.i_tx_done   = 1'b0;

        // 1. Reset dominates start and tx_done
        bus.i_start   = 1'b1;
        bus.i_tx_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_tx_data_%0d", i),  {24'd0, bus.o_tx_data}, 32'd0);
            check($sformatf("rst_tx_start_%0d", i), {31'd0, bus.o_tx_start}, 32'd0);
            check($sformatf("rst_busy_%0d", i),     {31'd0, bus.o_busy}, 32'd0);
            check($sformatf("rst_done_%0d", i),     {31'd0, bus.o_done}, 32'd0);
        end
        bus.i_start   = 1'b0;
        bus.i_tx_done = 1'b0;
        rst           = 1'b1;
        s0 = n_start_seen;
        repeat (5) tick();
        check("post_rst_no_start", n_start_seen - s0, 0);
        check("post_rst_busy", {31'd0, bus.o_busy}, 32'd0);

        // 2. Full frame, fixed latency, byte k of dump = k
        da = mk_data(1, 0);
        s0 = n_start_seen;
        d0 = n_done_seen;
        start_frame(32'h0102_0304, da);
        run_frame(0, -1, -1, 1'b0, '0, '0);
        check("f2_len", got_n, 324);
        check("f2_b0",   {24'd0, got[0]},   32'h01);
        check("f2_b1",   {24'd0, got[1]},   32'h02);
        check("f2_b2",   {24'd0, got[2]},   32'h03);
        check("f2_b3",   {24'd0, got[3]},   32'h04);
        check("f2_b4",   {24'd0, got[4]},   32'h00);
        check("f2_b5",   {24'd0, got[5]},   32'h01);
        check("f2_b259", {24'd0, got[259]}, 32'hFF);
        check("f2_b260", {24'd0, got[260]}, 32'h00);
        check("f2_b323", {24'd0, got[323]}, 32'h3F);
        for (int k = 4; k < got_n; k++)
            check($sformatf("f2_seq_b%0d", k), {24'd0, got[k]}, (k - 4) & 32'hFF);
        check("f2_starts", n_start_seen - s0, 324);
        check("f2_dones",  n_done_seen - d0, 1);
        check("f2_busy_after", {31'd0, bus.o_busy}, 32'd0);

        // 3. Random handshake latency
        da = mk_data(7, 3);
        d0 = n_done_seen;
        start_frame(32'hDEAD_BEEF, da);
        run_frame(1, -1, -1, 1'b0, '0, '0);
        check_frame("f3", 32'hDEAD_BEEF, da);
        check("f3_dones", n_done_seen - d0, 1);

        // 4. Snapshot isolation and ignored start while busy
        da = mk_data(3, 1);
        db = mk_data(5, 200);
        s0 = n_start_seen;
        d0 = n_done_seen;
        start_frame(32'hA5C3_0F81, da);
        run_frame(0, -1, 10, 1'b0, 32'h1111_2222, db);
        check_frame("f4", 32'hA5C3_0F81, da);
        repeat (10) tick();
        check("f4_starts", n_start_seen - s0, 324);
        check("f4_dones",  n_done_seen - d0, 1);

        // 5. Reset at byte 100 aborts silently; next frame restarts at byte 0
        da = mk_data(1, 17);
        d0 = n_done_seen;
        start_frame(32'h7766_5544, da);
        run_frame(0, 100, -1, 1'b0, '0, '0);
        check("f5_abort_len", got_n, 101);
        check("f5_abort_dones", n_done_seen - d0, 0);
        check("f5_abort_busy", {31'd0, bus.o_busy}, 32'd0);
        db = mk_data(9, 4);
        s0 = n_start_seen;
        start_frame(32'hCAFE_F00D, db);
        check("f5_first_byte", {24'd0, bus.o_tx_data}, 32'hCA);
        run_frame(0, -1, -1, 1'b0, '0, '0);
        check_frame("f5", 32'hCAFE_F00D, db);
        check("f5_starts", n_start_seen - s0, 324);
        check("f5_dones", n_done_seen - d0, 1);

        // 6. Spurious tx_done in IDLE and in every START cycle
        s0 = n_start_seen;
        bus.i_tx_done = 1'b1;
        tick();
        tick();
        bus.i_tx_done = 1'b0;
        check("f6_idle_busy", {31'd0, bus.o_busy}, 32'd0);
        check("f6_idle_no_start", n_start_seen - s0, 0);
        da = mk_data(11, 5);
        d0 = n_done_seen;
        start_frame(32'h0BAD_D00D, da);
        run_frame(0, -1, -1, 1'b1, '0, '0);
        check_frame("f6", 32'h0BAD_D00D, da);
        check("f6_starts", n_start_seen - s0, 324);
        check("f6_dones", n_done_seen - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
